i2s_frame_ctrl: RTL and testbench

//  Bus master and sequencer for one i2s_trx instance. Generates lrclk from bclk and drives the
//  trx reset/enable start-up sequence (reset, warm-up, run, drain). Bridges trx samples to and

---
 rtl/i2s_frame_ctrl_pkg.sv | 24 ++
 rtl/i2s_frame_ctrl_timer.sv | 40 ++++
 rtl/i2s_frame_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_i2s_frame_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_frame_ctrl_pkg.sv
// Shared types and helpers for the i2s frame controller.
// State encodings match the i2s_trx bench expectations (3 bits).
package i2s_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_TRX = 3'd1,
        ST_WARMUP    = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic is_active(input state_t s);
        return (s == ST_WARMUP) || (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/i2s_frame_ctrl_timer.sv
// Frame timer: bit counter, registered lrclk, wrap and mid-frame strobes.
// start loads bit 0 with lrclk high so the first frame is full length.
module i2s_frame_ctrl_timer #(
    parameter int SLOT_BITS = 32
) (
    input  logic bclk,
    input  logic reset,
    input  logic clr,
    input  logic start,
    input  logic en,
    output logic lrclk,
    output logic wrap,
    output logic mid
);

    localparam int W = $clog2(2 * SLOT_BITS);
    localparam logic [W-1:0] LAST = W'(2 * SLOT_BITS - 1);
    localparam logic [W-1:0] MID  = W'(SLOT_BITS);

    logic [W-1:0] bit_ctr;
    logic [W-1:0] ctr_nxt;

    assign wrap    = (bit_ctr == LAST);
    assign mid     = (bit_ctr == MID);
    assign ctr_nxt = wrap ? '0 : bit_ctr + 1'b1;

    always_ff @(posedge bclk) begin
        if (reset || clr) begin
            bit_ctr <= '0;
            lrclk   <= 1'b0;
        end else if (start) begin
            bit_ctr <= '0;
            lrclk   <= 1'b1;
        end else if (en) begin
            bit_ctr <= ctr_nxt;
            lrclk   <= (ctr_nxt < MID);
        end
    end

endmodule

// File: rtl/i2s_frame_ctrl.sv
// Bus master and sequencer for one i2s_trx: lrclk generation, trx start-up
// sequencing, and DSP-side tx/rx bridging with underrun/overrun accounting.
module i2s_frame_ctrl
    import i2s_frame_ctrl_pkg::*;
#(
    parameter int SAMPLE_SIZE   = 16,
    parameter int SLOT_BITS     = 32,
    parameter int RESET_CYCLES  = 4,
    parameter int WARMUP_FRAMES = 4,
    parameter int UNDERRUN_HOLD = 0
) (
    input  logic                   bclk,
    input  logic                   reset,
    input  logic                   run,
    output logic                   lrclk,
    output logic                   trx_reset,
    output logic                   trx_enable,
    input  logic                   trx_rx_valid,
    input  logic [SAMPLE_SIZE-1:0] trx_rx_l,
    input  logic [SAMPLE_SIZE-1:0] trx_rx_r,
    output logic [SAMPLE_SIZE-1:0] trx_tx_l,
    output logic [SAMPLE_SIZE-1:0] trx_tx_r,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [SAMPLE_SIZE-1:0] rx_l,
    output logic [SAMPLE_SIZE-1:0] rx_r,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [SAMPLE_SIZE-1:0] tx_l,
    input  logic [SAMPLE_SIZE-1:0] tx_r,
    output logic                   running,
    output logic [CNT_W-1:0]       underrun_cnt,
    output logic [CNT_W-1:0]       overrun_cnt
);

    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam int WF_W = $clog2(WARMUP_FRAMES + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [WF_W-1:0] WF_LAST = WF_W'(WARMUP_FRAMES - 1);

    state_t state;
    state_t nxt;

    logic [RC_W-1:0] rst_cnt;
    logic [WF_W-1:0] warm_cnt;

    logic wrap;
    logic mid;
    logic tmr_clr;
    logic tmr_start;
    logic tmr_en;

    logic                   hold_valid;
    logic                   hold_nxt;
    logic [SAMPLE_SIZE-1:0] hold_l;
    logic [SAMPLE_SIZE-1:0] hold_r;

    logic streaming;
    logic xfer;
    logic tx_fire;
    logic rx_fire;

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (run) nxt = ST_RESET_TRX;
            end
            ST_RESET_TRX: begin
                if (!run) nxt = ST_IDLE;
                else if (rst_cnt == RC_LAST) nxt = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (!run) nxt = ST_IDLE;
                else if (wrap && warm_cnt == WF_LAST) nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!run) nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wrap) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    assign tmr_start = (state == ST_RESET_TRX) && (nxt == ST_WARMUP);
    assign tmr_clr   = !tmr_start && !is_active(nxt);
    assign tmr_en    = is_active(state) && is_active(nxt);

    i2s_frame_ctrl_timer #(
        .SLOT_BITS(SLOT_BITS)
    ) u_timer (
        .bclk (bclk),
        .reset(reset),
        .clr  (tmr_clr),
        .start(tmr_start),
        .en   (tmr_en),
        .lrclk(lrclk),
        .wrap (wrap),
        .mid  (mid)
    );

    always_ff @(posedge bclk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rst_cnt    <= '0;
            warm_cnt   <= '0;
            trx_reset  <= 1'b1;
            trx_enable <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= nxt;
            trx_reset  <= !is_active(nxt);
            trx_enable <= is_active(nxt);
            running    <= (nxt == ST_RUN);
            if (state != nxt) begin
                rst_cnt  <= '0;
                warm_cnt <= '0;
            end else begin
                if (state == ST_RESET_TRX) rst_cnt <= rst_cnt + RC_W'(1);
                if (state == ST_WARMUP && wrap) warm_cnt <= warm_cnt + WF_W'(1);
            end
        end
    end

    // Transfer happens mid-frame, well away from the trx latch at frame start.
    assign streaming = (state == ST_RUN) || (state == ST_DRAIN);
    assign xfer      = streaming && mid;
    assign tx_fire   = tx_valid && tx_ready;
    assign rx_fire   = rx_valid && rx_ready;

    always_comb begin
        hold_nxt = hold_valid;
        if (state == ST_IDLE) hold_nxt = 1'b0;
        else if (tx_fire) hold_nxt = 1'b1;
        else if (xfer) hold_nxt = 1'b0;
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            hold_valid   <= 1'b0;
            hold_l       <= '0;
            hold_r       <= '0;
            tx_ready     <= 1'b1;
            trx_tx_l     <= '0;
            trx_tx_r     <= '0;
            underrun_cnt <= '0;
        end else begin
            hold_valid <= hold_nxt;
            tx_ready   <= !hold_nxt;
            if (tx_fire) begin
                hold_l <= tx_l;
                hold_r <= tx_r;
            end
            if (!streaming) begin
                trx_tx_l <= '0;
                trx_tx_r <= '0;
            end else if (xfer) begin
                if (hold_valid) begin
                    trx_tx_l <= hold_l;
                    trx_tx_r <= hold_r;
                end else begin
                    underrun_cnt <= sat_inc(underrun_cnt);
                    if (UNDERRUN_HOLD == 0) begin
                        trx_tx_l <= '0;
                        trx_tx_r <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            rx_valid    <= 1'b0;
            rx_l        <= '0;
            rx_r        <= '0;
            overrun_cnt <= '0;
        end else if (state == ST_IDLE) begin
            rx_valid <= 1'b0;
        end else if (streaming && trx_rx_valid) begin
            if (!rx_valid || rx_ready) begin
                rx_l     <= trx_rx_l;
                rx_r     <= trx_rx_r;
                rx_valid <= 1'b1;
            end else begin
                overrun_cnt <= sat_inc(overrun_cnt);
            end
        end else if (rx_fire) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed bench for i2s_frame_ctrl: start-up vector table plus hand
// sequences for loopback, underrun, overrun, drain and mid-stream reset.
module tb_i2s_frame_ctrl;

    logic        bclk = 1'b0;
    logic        reset;
    logic        run;
    logic        trx_rx_valid = 1'b0;
    logic [15:0] trx_rx_l = '0;
    logic [15:0] trx_rx_r = '0;
    logic        rx_ready;
    logic        tx_valid;
    logic [15:0] tx_l;
    logic [15:0] tx_r;

    logic        lrclk, trx_reset, trx_enable, rx_valid, tx_ready, running;
    logic [15:0] trx_tx_l, trx_tx_r, rx_l, rx_r, underrun_cnt, overrun_cnt;

    logic        h_lrclk, h_trx_reset, h_trx_enable, h_rx_valid, h_tx_ready;
    logic        h_running;
    logic [15:0] h_trx_tx_l, h_trx_tx_r, h_rx_l, h_rx_r;
    logic [15:0] h_underrun_cnt, h_overrun_cnt;

    always #5 bclk = ~bclk;

    i2s_frame_ctrl u_dut (
        .bclk(bclk), .reset(reset), .run(run), .lrclk(lrclk),
        .trx_reset(trx_reset), .trx_enable(trx_enable),
        .trx_rx_valid(trx_rx_valid), .trx_rx_l(trx_rx_l), .trx_rx_r(trx_rx_r),
        .trx_tx_l(trx_tx_l), .trx_tx_r(trx_tx_r),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_l(rx_l), .rx_r(rx_r),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_l(tx_l), .tx_r(tx_r),
        .running(running), .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt)
    );

    i2s_frame_ctrl #(.UNDERRUN_HOLD(1)) u_hold (
        .bclk(bclk), .reset(reset), .run(run), .lrclk(h_lrclk),
        .trx_reset(h_trx_reset), .trx_enable(h_trx_enable),
        .trx_rx_valid(trx_rx_valid), .trx_rx_l(trx_rx_l), .trx_rx_r(trx_rx_r),
        .trx_tx_l(h_trx_tx_l), .trx_tx_r(h_trx_tx_r),
        .rx_valid(h_rx_valid), .rx_ready(rx_ready), .rx_l(h_rx_l), .rx_r(h_rx_r),
        .tx_valid(tx_valid), .tx_ready(h_tx_ready), .tx_l(tx_l), .tx_r(tx_r),
        .running(h_running), .underrun_cnt(h_underrun_cnt),
        .overrun_cnt(h_overrun_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Frame position as seen between edges; equals the DUT bit counter.
    int          pos = 0;
    logic        lrclk_q = 1'b0;
    logic        pat_mode = 1'b0;
    int          pat_n = 0;
    logic [15:0] cap_l = '0, cap_r = '0, dly_l = '0, dly_r = '0;
    logic [15:0] emit_l = '0, emit_r = '0;

    // trx model: latches the tx pair at frame start, returns it one frame later.
    always @(negedge bclk) begin
        trx_rx_valid = 1'b0;
        if (lrclk && !lrclk_q) pos = 0;
        else pos = pos + 1;
        lrclk_q = lrclk;
        if (pos == 0) begin
            dly_l = cap_l;
            dly_r = cap_r;
            cap_l = trx_tx_l;
            cap_r = trx_tx_r;
        end
        if (pos == 5) begin
            if (pat_mode) begin
                pat_n  = pat_n + 1;
                emit_l = 16'hB000 + 16'(pat_n);
                emit_r = 16'hC000 + 16'(pat_n);
            end else begin
                emit_l = dly_l;
                emit_r = dly_r;
            end
            trx_rx_l     = emit_l;
            trx_rx_r     = emit_r;
            trx_rx_valid = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge bclk);
        #1;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        do begin
            tick();
            n++;
        end while (pos != p && n < 200);
        chk($sformatf("wait_pos%0d", p), 32'(pos), 32'(p));
    endtask

    typedef struct {
        int          k;
        logic        trx_reset;
        logic        trx_enable;
        logic        lrclk;
        logic        running;
        logic [15:0] trx_tx_l;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held_l, held_r;
        int n;

        tbl[0]  = '{0,   1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[1]  = '{1,   1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[2]  = '{4,   1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[3]  = '{5,   1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
        tbl[4]  = '{36,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
        tbl[5]  = '{37,  1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
        tbl[6]  = '{68,  1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
        tbl[7]  = '{69,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
        tbl[8]  = '{260, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
        tbl[9]  = '{261, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0};
        tbl[10] = '{293, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0};
        tbl[11] = '{294, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234};
        tbl[12] = '{300, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234};

        reset    = 1'b1;
        run      = 1'b1;
        rx_ready = 1'b1;
        tx_valid = 1'b1;
        tx_l     = 16'h1234;
        tx_r     = 16'h5678;
        repeat (3) tick();

        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_underrun", 32'(underrun_cnt), 0);
        chk("rst_overrun", 32'(overrun_cnt), 0);
        chk("rst_rx_l", 32'(rx_l), 0);

        for (int k = 0; k <= 300; k++) begin
            if (k == 1) reset = 1'b0;
            if (k > 0) tick();
            for (int i = 0; i < 13; i++) begin
                if (tbl[i].k == k) begin
                    chk($sformatf("k%0d_trx_reset", k), 32'(trx_reset),
                        32'(tbl[i].trx_reset));
                    chk($sformatf("k%0d_trx_enable", k), 32'(trx_enable),
                        32'(tbl[i].trx_enable));
                    chk($sformatf("k%0d_lrclk", k), 32'(lrclk),
                        32'(tbl[i].lrclk));
                    chk($sformatf("k%0d_running", k), 32'(running),
                        32'(tbl[i].running));
                    chk($sformatf("k%0d_trx_tx_l", k), 32'(trx_tx_l),
                        32'(tbl[i].trx_tx_l));
                end
            end
            if (k == 0) reset = 1'b0;
        end

        // Loopback: zeros captured in frame 0 of RUN, 1234 from frame 1.
        wait_pos(6);
        chk("lb_r1_valid", 32'(rx_valid), 1);
        chk("lb_r1_l", 32'(rx_l), 0);
        wait_pos(6);
        chk("lb_r2_valid", 32'(rx_valid), 1);
        chk("lb_r2_l", 32'(rx_l), 32'h1234);
        chk("lb_r2_r", 32'(rx_r), 32'h5678);
        chk("lb_underrun", 32'(underrun_cnt), 0);
        chk("lb_overrun", 32'(overrun_cnt), 0);

        // Underrun: the held pair goes out once, then three empty slots.
        wait_pos(40);
        tx_valid = 1'b0;
        wait_pos(33);
        chk("ur_r3_tx_l", 32'(trx_tx_l), 32'h1234);
        chk("ur_r3_cnt", 32'(underrun_cnt), 0);
        wait_pos(33);
        chk("ur_r4_tx_l", 32'(trx_tx_l), 0);
        chk("ur_r4_tx_r", 32'(trx_tx_r), 0);
        chk("ur_r4_hold_l", 32'(h_trx_tx_l), 32'h1234);
        chk("ur_r4_hold_r", 32'(h_trx_tx_r), 32'h5678);
        chk("ur_r4_cnt", 32'(underrun_cnt), 1);
        wait_pos(33);
        wait_pos(33);
        chk("ur_r6_cnt", 32'(underrun_cnt), 3);
        chk("ur_r6_hold_cnt", 32'(h_underrun_cnt), 3);
        chk("ur_r6_hold_l", 32'(h_trx_tx_l), 32'h1234);
        wait_pos(40);
        tx_valid = 1'b1;
        tx_l     = 16'hAAAA;
        tx_r     = 16'h5555;
        wait_pos(33);
        chk("ur_r7_tx_l", 32'(trx_tx_l), 32'hAAAA);
        chk("ur_r7_tx_r", 32'(trx_tx_r), 32'h5555);
        chk("ur_r7_hold_l", 32'(h_trx_tx_l), 32'hAAAA);
        chk("ur_r7_cnt", 32'(underrun_cnt), 3);

        // Overrun: DSP stalls five frames, first pair must survive.
        pat_mode = 1'b1;
        wait_pos(0);
        rx_ready = 1'b0;
        wait_pos(6);
        held_l = emit_l;
        held_r = emit_r;
        chk("or_first_valid", 32'(rx_valid), 1);
        chk("or_first_l", 32'(rx_l), 32'(held_l));
        repeat (5) wait_pos(0);
        chk("or_held_valid", 32'(rx_valid), 1);
        chk("or_held_l", 32'(rx_l), 32'(held_l));
        chk("or_held_r", 32'(rx_r), 32'(held_r));
        chk("or_cnt", 32'(overrun_cnt), 4);
        rx_ready = 1'b1;
        tick();
        chk("or_drained", 32'(rx_valid), 0);
        wait_pos(6);
        chk("or_new_valid", 32'(rx_valid), 1);
        chk("or_new_l", 32'(rx_l), 32'(emit_l));
        chk("or_new_r", 32'(rx_r), 32'(emit_r));
        chk("or_cnt_after", 32'(overrun_cnt), 4);

        // Drain: stop at bit 10, re-assert mid-drain, idle after bit 63.
        wait_pos(10);
        run = 1'b0;
        tick();
        chk("dr_running", 32'(running), 0);
        chk("dr_enable", 32'(trx_enable), 1);
        wait_pos(30);
        run = 1'b1;
        wait_pos(63);
        chk("dr_63_enable", 32'(trx_enable), 1);
        chk("dr_63_reset", 32'(trx_reset), 0);
        chk("dr_63_running", 32'(running), 0);
        tick();
        chk("dr_idle_enable", 32'(trx_enable), 0);
        chk("dr_idle_reset", 32'(trx_reset), 1);
        chk("dr_idle_lrclk", 32'(lrclk), 0);
        n = 0;
        while (!running && n < 600) begin
            tick();
            n++;
        end
        chk("restart_running", 32'(running), 1);

        // Mid-stream reset at bit 40.
        wait_pos(40);
        chk("pre_rst_underrun", 32'(underrun_cnt), 3);
        chk("pre_rst_overrun", 32'(overrun_cnt), 4);
        reset = 1'b1;
        tick();
        chk("mr_lrclk", 32'(lrclk), 0);
        chk("mr_trx_reset", 32'(trx_reset), 1);
        chk("mr_trx_enable", 32'(trx_enable), 0);
        chk("mr_running", 32'(running), 0);
        chk("mr_tx_ready", 32'(tx_ready), 1);
        chk("mr_rx_valid", 32'(rx_valid), 0);
        chk("mr_trx_tx_l", 32'(trx_tx_l), 0);
        chk("mr_rx_l", 32'(rx_l), 0);
        chk("mr_underrun", 32'(underrun_cnt), 0);
        chk("mr_overrun", 32'(overrun_cnt), 0);
        chk("mr_hold_underrun", 32'(h_underrun_cnt), 0);
        reset = 1'b0;
        run   = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
